// File: rtl/sr_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sr_seq_shifter
// Description : Multi-cycle right shifter (logical or arithmetic) with a
//               start / result-ready handshake. Operands are captured when a
//               start is accepted in IDLE. The result appears after a
//               shift-amount-dependent number of cycles and is held until the
//               next result is produced.
//
// Ports       : clock          - rising-edge clock
//               reset          - synchronous, active-high reset
//               ctrl_start     - start request, sampled only while idle
//               data_in        - operand, captured on accepted start
//               ctrl_shiftamt  - shift amount, captured on accepted start
//               ctrl_arith     - 1 = sign fill, 0 = zero fill; captured
//               data_out       - last completed result, held between ops
//               data_resultRDY - one-cycle pulse when data_out is new
//               busy           - high while an operation is in flight
//
// Options     : SR_SHIFT_BY_FOUR_EN - when defined, shift by 4 per cycle while
//               the remaining count is >= 4, otherwise by 1. Results are
//               bit-identical; only the latency changes.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sr_seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic               ctrl_arith,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [SHAMT_W-1:0] r_count;
    logic               r_fill;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_rdy;

    logic [WIDTH-1:0]   w_shreg_next;
    logic [SHAMT_W-1:0] w_count_next;

`ifdef SR_SHIFT_BY_FOUR_EN
    // Coarse steps of 4 while enough shift remains, then finish bit by bit.
    logic w_step4;
    assign w_step4 = (r_count >= SHAMT_W'(4));

    always_comb begin
        w_shreg_next = {r_fill, r_shreg[WIDTH-1:1]};
        w_count_next = r_count - SHAMT_W'(1);
        if (w_step4) begin
            w_shreg_next = {{4{r_fill}}, r_shreg[WIDTH-1:4]};
            w_count_next = r_count - SHAMT_W'(4);
        end
    end
`else
    always_comb begin
        w_shreg_next = {r_fill, r_shreg[WIDTH-1:1]};
        w_count_next = r_count - SHAMT_W'(1);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_shreg    <= '0;
            r_count    <= '0;
            r_fill     <= 1'b0;
            r_data_out <= '0;
            r_rdy      <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (ctrl_start) begin
                        r_shreg <= data_in;
                        r_count <= ctrl_shiftamt;
                        // Fill bit is fixed at capture time: the operand sign
                        // for arithmetic shifts, zero for logical shifts.
                        r_fill  <= ctrl_arith & data_in[WIDTH-1];
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_count == '0) begin
                        r_data_out <= r_shreg;
                        r_rdy      <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_shreg <= w_shreg_next;
                        r_count <= w_count_next;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign data_out       = r_data_out;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state == c_ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_sr_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_seq_shifter
// Description : Directed self-checking bench for sr_seq_shifter. Latency
//               expectations follow SR_SHIFT_BY_FOUR_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_seq_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clock = 1'b0;
    logic               reset;
    logic               ctrl_start;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic               ctrl_arith;
    logic [WIDTH-1:0]   data_out;
    logic               data_resultRDY;
    logic               busy;

    int checks = 0;
    int errors = 0;

    sr_seq_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .data_in        (data_in),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .ctrl_arith     (ctrl_arith),
        .data_out       (data_out),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    function automatic int lat(input int n);
`ifdef SR_SHIFT_BY_FOUR_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    // Drive a start at the negedge, let the next posedge accept it, then
    // scramble the operand inputs so late changes would corrupt a bad design.
    task automatic start_op(input logic [WIDTH-1:0] d, input int n, input logic a);
        @(negedge clock);
        ctrl_start    = 1'b1;
        data_in       = d;
        ctrl_shiftamt = SHAMT_W'(n);
        ctrl_arith    = a;
        @(posedge clock);
        #1;
        ctrl_start    = 1'b0;
        data_in       = ~d;
        ctrl_shiftamt = ~SHAMT_W'(n);
        ctrl_arith    = ~a;
    endtask

    // Count edges after acceptance until data_resultRDY is seen (bounded).
    task automatic wait_rdy(output int edges, output bit timed_out);
        edges     = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            #1;
            edges++;
            if (data_resultRDY) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_start = 1'b1; data_in = 32'hFFFF_FFFF;
        ctrl_shiftamt = 5'd3; ctrl_arith = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (data_out !== 32'h0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h rdy=%b busy=%b, want 0/0/0",
                     data_out, data_resultRDY, busy);
        end
        @(negedge clock);
        reset = 1'b0; ctrl_start = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_shift();
        logic [WIDTH-1:0] vd [6] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                                     32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
        int               vn [6] = '{4, 4, 31, 31, 31, 7};
        logic             va [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [WIDTH-1:0] ve [6] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0000,
                                     32'hFFFF_FFFF, 32'h0000_0001, 32'hFFBD_5B7D};
        int edges;
        bit to;
        for (int i = 0; i < 6; i++) begin
            start_op(vd[i], vn[i], va[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL shift_busy[%0d]: got %b, want 1", i, busy);
            end
            wait_rdy(edges, to);
            checks++;
            if (to || edges !== lat(vn[i])) begin
                errors++;
                $display("FAIL shift_latency[%0d]: got %0d edges (timeout=%0d), want %0d",
                         i, edges, to, lat(vn[i]));
            end
            checks++;
            if (data_out !== ve[i]) begin
                errors++;
                $display("FAIL shift_result[%0d]: got %h, want %h", i, data_out, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        bit to;
        start_op(32'h1234_5678, 0, 1'b0);
        wait_rdy(edges, to);
        checks++;
        if (to || edges !== 1 || data_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL zero_shift: got %h after %0d edges, want 12345678 after 1",
                     data_out, edges);
        end
        // Second start driven while the first result's RDY is still high.
        start_op(32'hA5A5_A5A5, 1, 1'b1);
        checks++;
        if (busy !== 1'b1 || data_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b out=%h, want 1/12345678", busy, data_out);
        end
        wait_rdy(edges, to);
        checks++;
        if (to || edges !== lat(1) || data_out !== 32'hD2D2_D2D2) begin
            errors++;
            $display("FAIL b2b_result: got %h after %0d edges, want d2d2d2d2 after %0d",
                     data_out, edges, lat(1));
        end
    endtask

    task automatic test_start_while_busy();
        int l  = lat(8);
        int pe = (l > 3) ? 3 : 2;
        int pulses = 0;
        int busy_bad = 0;
        logic [WIDTH-1:0] res = '0;
        start_op(32'hF000_0000, 8, 1'b1);
        for (int k = 1; k <= l + 3; k++) begin
            @(negedge clock);
            ctrl_start    = (k == pe);
            data_in       = 32'h0000_0001;
            ctrl_shiftamt = 5'd1;
            ctrl_arith    = 1'b0;
            @(posedge clock);
            #1;
            if (k < l && busy !== 1'b1) busy_bad++;
            if (data_resultRDY) begin
                pulses++;
                res = data_out;
            end
        end
        ctrl_start = 1'b0;
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL ignore_busy: got %0d cycles with busy low, want 0", busy_bad);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_pulses: got %0d RDY pulses, want 1", pulses);
        end
        checks++;
        if (res !== 32'hFFF0_0000) begin
            errors++;
            $display("FAIL ignore_result: got %h, want fff00000", res);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        int edges;
        bit to;
        start_op(32'h8765_4321, 20, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            reset = (k == 6);
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (data_out !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got out=%h busy=%b rdy=%b, want 0/0/0",
                     data_out, busy, data_resultRDY);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_rdy: got %0d RDY pulses, want 0", pulses);
        end
        start_op(32'h8000_0000, 4, 1'b1);
        wait_rdy(edges, to);
        checks++;
        if (to || edges !== lat(4) || data_out !== 32'hF800_0000) begin
            errors++;
            $display("FAIL after_abort: got %h after %0d edges, want f8000000 after %0d",
                     data_out, edges, lat(4));
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
